// File: rtl/digit_roi_sequencer.sv
// digit_roi_sequencer
//   Per-frame controller sitting between the digit bounding-box tracker and the
//   digit recogniser. Once per frame, at a fixed raster point, it samples the
//   tracker's box and checks its size. It also checks how much the box moved
//   since the last valid frame. After STABLE_FRAMES consecutive valid, stable
//   frames it latches the box as the ROI and fires one recognition. It then
//   waits for done or timeout and re-arms.
//
// Ports
//   clk, rst          pixel clock, synchronous active-high reset
//   RGB_x_Src/_y_Src  current raster position
//   box_*             tracker box edges (left/right 11 bit, top/bottom 10 bit)
//   rec_done/digit    recogniser completion pulse and its result
//   rec_start         one-cycle start pulse to the recogniser
//   roi_*             latched ROI, constant from rec_start until back in WAIT
//   busy              high while a recognition is being launched or awaited
//   digit_out/valid   last recognised digit and its one-cycle update pulse
//   timeout_pulse     one-cycle pulse when a recognition is abandoned
module digit_roi_sequencer #(
  parameter logic [10:0] SAMPLE_X      = 11'd1220,
  parameter logic [9:0]  SAMPLE_Y      = 10'd602,
  parameter logic [10:0] MIN_W         = 11'd20,
  parameter logic [9:0]  MIN_H         = 10'd20,
  parameter int          TOL           = 4,
  parameter int          STABLE_FRAMES = 3,
  parameter logic [15:0] TIMEOUT       = 16'd50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] RGB_x_Src,
  input  logic [9:0]  RGB_y_Src,
  input  logic [10:0] box_left,
  input  logic [10:0] box_right,
  input  logic [9:0]  box_top,
  input  logic [9:0]  box_bottom,
  input  logic        rec_done,
  input  logic [3:0]  rec_digit,
  output logic        rec_start,
  output logic [10:0] roi_left,
  output logic [10:0] roi_right,
  output logic [9:0]  roi_top,
  output logic [9:0]  roi_bottom,
  output logic        busy,
  output logic [3:0]  digit_out,
  output logic        digit_valid,
  output logic        timeout_pulse
);

  typedef enum logic [1:0] {S_WAIT, S_EVAL, S_START, S_BUSY} state_t;

  // Edge differences are taken one bit wider and signed, so an inverted
  // (empty-frame) box gives a negative span instead of wrapping.
  function automatic logic signed [11:0] span_x(input logic [10:0] hi, input logic [10:0] lo);
    return $signed({1'b0, hi}) - $signed({1'b0, lo});
  endfunction

  function automatic logic signed [10:0] span_y(input logic [9:0] hi, input logic [9:0] lo);
    return $signed({1'b0, hi}) - $signed({1'b0, lo});
  endfunction

  function automatic logic [11:0] adiff_x(input logic [10:0] a, input logic [10:0] b);
    logic signed [11:0] d;
    d = span_x(a, b);
    return (d < 0) ? $unsigned(-d) : $unsigned(d);
  endfunction

  function automatic logic [10:0] adiff_y(input logic [9:0] a, input logic [9:0] b);
    logic signed [10:0] d;
    d = span_y(a, b);
    return (d < 0) ? $unsigned(-d) : $unsigned(d);
  endfunction

  state_t      state_q, state_d;
  logic        match_q, match_d;
  logic [10:0] new_l_q, new_l_d, new_r_q, new_r_d;
  logic [9:0]  new_t_q, new_t_d, new_b_q, new_b_d;
  logic [10:0] held_l_q, held_l_d, held_r_q, held_r_d;
  logic [9:0]  held_t_q, held_t_d, held_b_q, held_b_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] timer_q, timer_d;
  logic [10:0] roi_l_q, roi_l_d, roi_r_q, roi_r_d;
  logic [9:0]  roi_t_q, roi_t_d, roi_b_q, roi_b_d;
  logic        start_q, start_d, busy_q, busy_d, dv_q, dv_d, to_q, to_d;
  logic [3:0]  digit_q, digit_d;

  logic        sample_evt, box_ok, box_stable;
  logic [3:0]  cnt_upd;
  logic signed [11:0] w_span;
  logic signed [10:0] h_span;

  // Validity and stability of the box captured in WAIT, used during EVAL.
  always_comb begin
    w_span     = span_x(new_r_q, new_l_q);
    h_span     = span_y(new_b_q, new_t_q);
    box_ok     = (w_span > 12'sd0) && (w_span >= $signed({1'b0, MIN_W})) &&
                 (h_span > 11'sd0) && (h_span >= $signed({1'b0, MIN_H}));
    box_stable = (adiff_x(new_l_q, held_l_q) <= 12'(TOL)) &&
                 (adiff_x(new_r_q, held_r_q) <= 12'(TOL)) &&
                 (adiff_y(new_t_q, held_t_q) <= 11'(TOL)) &&
                 (adiff_y(new_b_q, held_b_q) <= 11'(TOL));
  end

  always_comb begin
    state_d  = state_q;
    match_d  = (RGB_x_Src == SAMPLE_X) && (RGB_y_Src == SAMPLE_Y);
    // Rising edge of the match only: dwelling on the point fires once.
    sample_evt = match_d && !match_q;
    new_l_d  = new_l_q;  new_r_d  = new_r_q;  new_t_d  = new_t_q;  new_b_d  = new_b_q;
    held_l_d = held_l_q; held_r_d = held_r_q; held_t_d = held_t_q; held_b_d = held_b_q;
    roi_l_d  = roi_l_q;  roi_r_d  = roi_r_q;  roi_t_d  = roi_t_q;  roi_b_d  = roi_b_q;
    cnt_d    = cnt_q;
    cnt_upd  = cnt_q;
    timer_d  = timer_q;
    start_d  = 1'b0;
    busy_d   = busy_q;
    digit_d  = digit_q;
    dv_d     = 1'b0;
    to_d     = 1'b0;
    case (state_q)
      S_WAIT: begin
        if (sample_evt) begin
          new_l_d = box_left;  new_r_d = box_right;
          new_t_d = box_top;   new_b_d = box_bottom;
          state_d = S_EVAL;
        end
      end
      S_EVAL: begin
        if (!box_ok) begin
          // Held box is left alone; only the run of stable frames restarts.
          cnt_d   = 4'd0;
          state_d = S_WAIT;
        end else begin
          if (box_stable) cnt_upd = (cnt_q == 4'd15) ? 4'd15 : cnt_q + 4'd1;
          else            cnt_upd = 4'd1;
          cnt_d    = cnt_upd;
          held_l_d = new_l_q; held_r_d = new_r_q;
          held_t_d = new_t_q; held_b_d = new_b_q;
          if (cnt_upd >= 4'(STABLE_FRAMES)) begin
            roi_l_d = new_l_q; roi_r_d = new_r_q;
            roi_t_d = new_t_q; roi_b_d = new_b_q;
            start_d = 1'b1;
            busy_d  = 1'b1;
            timer_d = 16'd0;
            state_d = S_START;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_START: begin
        // Timer reads 0 in START, so it equals TIMEOUT-1 exactly TIMEOUT-1
        // cycles after rec_start and the registered pulse lands at +TIMEOUT.
        timer_d = timer_q + 16'd1;
        state_d = S_BUSY;
      end
      S_BUSY: begin
        timer_d = timer_q + 16'd1;
        if (rec_done) begin
          digit_d = rec_digit;
          dv_d    = 1'b1;
          cnt_d   = 4'd0;
          busy_d  = 1'b0;
          state_d = S_WAIT;
        end else if (timer_q == TIMEOUT - 16'd1) begin
          to_d    = 1'b1;
          cnt_d   = 4'd0;
          busy_d  = 1'b0;
          state_d = S_WAIT;
        end
      end
      default: state_d = S_WAIT;
    endcase
  end

  always_ff @(posedge clk) begin
    // Captured box is only consumed in EVAL after a fresh capture.
    new_l_q <= new_l_d; new_r_q <= new_r_d; new_t_q <= new_t_d; new_b_q <= new_b_d;
    if (rst) begin
      state_q  <= S_WAIT;
      match_q  <= 1'b0;
      held_l_q <= '0; held_r_q <= '0; held_t_q <= '0; held_b_q <= '0;
      roi_l_q  <= '0; roi_r_q  <= '0; roi_t_q  <= '0; roi_b_q  <= '0;
      cnt_q    <= '0;
      timer_q  <= '0;
      start_q  <= 1'b0;
      busy_q   <= 1'b0;
      digit_q  <= '0;
      dv_q     <= 1'b0;
      to_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      match_q  <= match_d;
      held_l_q <= held_l_d; held_r_q <= held_r_d; held_t_q <= held_t_d; held_b_q <= held_b_d;
      roi_l_q  <= roi_l_d;  roi_r_q  <= roi_r_d;  roi_t_q  <= roi_t_d;  roi_b_q  <= roi_b_d;
      cnt_q    <= cnt_d;
      timer_q  <= timer_d;
      start_q  <= start_d;
      busy_q   <= busy_d;
      digit_q  <= digit_d;
      dv_q     <= dv_d;
      to_q     <= to_d;
    end
  end

  assign rec_start     = start_q;
  assign roi_left      = roi_l_q;
  assign roi_right     = roi_r_q;
  assign roi_top       = roi_t_q;
  assign roi_bottom    = roi_b_q;
  assign busy          = busy_q;
  assign digit_out     = digit_q;
  assign digit_valid   = dv_q;
  assign timeout_pulse = to_q;

endmodule

// File: tb/tb_digit_roi_sequencer.sv
// Testbench for digit_roi_sequencer: directed scenarios plus randomized frames,
// checked every cycle against a timestamp-based behavioural model.
`timescale 1ns/1ps
module tb_digit_roi_sequencer;
  localparam logic [10:0] SX = 11'd1220;
  localparam logic [9:0]  SY = 10'd602;
  localparam int MINW = 20, MINH = 20, TOLV = 4, SF = 3, TO = 64;

  logic        clk = 1'b0, rst = 1'b1;
  logic [10:0] x = '0, bl = '0, br = '0;
  logic [9:0]  y = '0, bt = '0, bb = '0;
  logic        rec_done = 1'b0;
  logic [3:0]  rec_digit = '0;
  logic        rec_start, busy, digit_valid, timeout_pulse;
  logic [10:0] roi_left, roi_right;
  logic [9:0]  roi_top, roi_bottom;
  logic [3:0]  digit_out;

  digit_roi_sequencer #(.TIMEOUT(16'(TO))) dut (
    .clk(clk), .rst(rst), .RGB_x_Src(x), .RGB_y_Src(y),
    .box_left(bl), .box_right(br), .box_top(bt), .box_bottom(bb),
    .rec_done(rec_done), .rec_digit(rec_digit), .rec_start(rec_start),
    .roi_left(roi_left), .roi_right(roi_right), .roi_top(roi_top), .roi_bottom(roi_bottom),
    .busy(busy), .digit_out(digit_out), .digit_valid(digit_valid), .timeout_pulse(timeout_pulse));

  always #5 clk = ~clk;

  int vecs = 0, errs = 0;
  bit chk_en = 1'b0;

  // ---------------- behavioural model (timestamps, not states) ----------------
  int cyc = 0;
  int start_cyc = -100, accept_from = 0;
  bit in_rec = 1'b0, mprev = 1'b0;
  int hl = 0, hr = 0, ht = 0, hb = 0, cnt = 0;
  int pl = 0, pr = 0, pt = 0, pb = 0;
  int e_rl = 0, e_rr = 0, e_rt = 0, e_rb = 0, e_digit = 0;
  bit e_start = 0, e_busy = 0, e_dv = 0, e_to = 0;

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  always @(posedge clk) begin
    int c, l, r, t, b;
    bit m, evt, ok, st;
    c = cyc;
    cyc = cyc + 1;
    e_start = 0; e_dv = 0; e_to = 0;
    if (rst) begin
      in_rec = 0; accept_from = 0; mprev = 0; start_cyc = -100;
      hl = 0; hr = 0; ht = 0; hb = 0; cnt = 0;
      e_rl = 0; e_rr = 0; e_rt = 0; e_rb = 0; e_digit = 0; e_busy = 0;
    end else begin
      m = (x == SX) && (y == SY);
      evt = m && !mprev;
      mprev = m;
      if (in_rec && c > start_cyc) begin
        if (rec_done) begin
          e_digit = int'(rec_digit); e_dv = 1; in_rec = 0; cnt = 0; accept_from = c + 1;
        end else if (c - start_cyc == TO - 1) begin
          e_to = 1; in_rec = 0; cnt = 0; accept_from = c + 1;
        end
      end
      if (in_rec && c + 1 == start_cyc) begin
        e_rl = pl; e_rr = pr; e_rt = pt; e_rb = pb;
      end
      if (evt && !in_rec && c >= accept_from) begin
        l = int'(bl); r = int'(br); t = int'(bt); b = int'(bb);
        ok = (r > l) && (r - l >= MINW) && (b > t) && (b - t >= MINH);
        if (!ok) cnt = 0;
        else begin
          st = iabs(l - hl) <= TOLV && iabs(r - hr) <= TOLV &&
               iabs(t - ht) <= TOLV && iabs(b - hb) <= TOLV;
          cnt = st ? ((cnt + 1 > 15) ? 15 : cnt + 1) : 1;
          hl = l; hr = r; ht = t; hb = b;
        end
        if (ok && cnt >= SF) begin
          in_rec = 1; start_cyc = c + 2;
          pl = l; pr = r; pt = t; pb = b;
        end
        accept_from = c + 2;
      end
      e_start = in_rec && (c + 1 == start_cyc);
      e_busy  = in_rec && (c + 1 >= start_cyc);
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      vecs++;
      if (rec_start !== e_start || busy !== e_busy || digit_valid !== e_dv ||
          timeout_pulse !== e_to || int'(digit_out) != e_digit ||
          int'(roi_left) != e_rl || int'(roi_right) != e_rr ||
          int'(roi_top) != e_rt || int'(roi_bottom) != e_rb || $isunknown(digit_out)) begin
        errs++;
        $display("FAIL cyc%0d outputs: start=%0b busy=%0b dv=%0b to=%0b digit=%0d roi=(%0d,%0d,%0d,%0d) required start=%0b busy=%0b dv=%0b to=%0b digit=%0d roi=(%0d,%0d,%0d,%0d)",
                 cyc, rec_start, busy, digit_valid, timeout_pulse, digit_out,
                 roi_left, roi_right, roi_top, roi_bottom,
                 e_start, e_busy, e_dv, e_to, e_digit, e_rl, e_rr, e_rt, e_rb);
      end
    end
  end

  // ---------------- event monitor for directed literal checks ----------------
  int start_cnt = 0, dv_cnt = 0, to_cnt = 0;
  int start_seen = -1, dv_seen = -1, to_seen = -1;
  always @(posedge clk) begin
    #2;
    if (rec_start === 1'b1)     begin start_cnt++; start_seen = cyc; end
    if (digit_valid === 1'b1)   begin dv_cnt++;    dv_seen = cyc;    end
    if (timeout_pulse === 1'b1) begin to_cnt++;    to_seen = cyc;    end
  end

  task automatic lit(input string name, input int act, input int req);
    vecs++;
    if (act != req) begin
      errs++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  int last_sample = 0, done_cyc = 0;

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      x = 11'd5; y = 10'd5; rec_done = 1'b0;
    end
  endtask

  task automatic frame(input int l, input int r, input int t, input int b);
    @(negedge clk);
    bl = 11'(l); br = 11'(r); bt = 10'(t); bb = 10'(b);
    x = SX; y = SY; last_sample = cyc;
    @(negedge clk);            // dwell on the sample point for a second cycle
    idle(4);
  endtask

  task automatic done(input int d);
    @(negedge clk);
    rec_done = 1'b1; rec_digit = 4'(d); done_cyc = cyc;
    @(negedge clk);
    rec_done = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic rand_cycle(input bit at_pt);
    @(negedge clk);
    x = at_pt ? SX : 11'($urandom_range(0, 1219));
    y = at_pt ? SY : 10'($urandom_range(0, 1023));
    rec_done  = ($urandom_range(0, 5) == 0);
    rec_digit = 4'($urandom_range(0, 15));
    rst       = ($urandom_range(0, 59) == 0);
  endtask

  initial begin
    int target, bx, by, bw, bh, dw, gp, l, r, t, b;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    rst = 1'b0;

    // Reset and idle raster
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); x = 11'(37 * i); y = 10'(11 * i);
    end
    #1;
    lit("idle_start_cnt", start_cnt, 0);
    lit("idle_busy", int'(busy), 0);
    lit("idle_digit", int'(digit_out), 0);
    lit("idle_roi_left", int'(roi_left), 0);

    // Stable launch
    repeat (3) frame(500, 700, 200, 400);
    #1;
    lit("launch_once", start_cnt, 1);
    lit("launch_latency", start_seen - last_sample, 2);
    lit("launch_roi_left", int'(roi_left), 500);
    lit("launch_roi_right", int'(roi_right), 700);
    lit("launch_roi_top", int'(roi_top), 200);
    lit("launch_roi_bottom", int'(roi_bottom), 400);
    lit("launch_busy", int'(busy), 1);
    idle(2);
    done(7);
    idle(2);
    #1;
    lit("done_digit", int'(digit_out), 7);
    lit("done_dv_cnt", dv_cnt, 1);
    lit("done_dv_latency", dv_seen - done_cyc, 1);
    lit("done_busy", int'(busy), 0);

    // Jitter and invalid boxes
    do_reset();
    frame(500, 700, 200, 400);
    frame(503, 698, 202, 401);
    frame(510, 700, 200, 400);
    #1 lit("jitter_no_start", start_cnt, 1);
    frame(510, 700, 200, 400);
    frame(510, 700, 200, 400);
    #1 lit("jitter_start", start_cnt, 2);
    done(3);
    idle(2);
    frame(510, 700, 200, 400);
    frame(510, 700, 200, 400);
    frame(830, 450, 590, 130);
    frame(510, 700, 200, 400);
    frame(510, 700, 200, 400);
    #1 lit("empty_no_start", start_cnt, 2);
    frame(510, 700, 200, 400);
    #1 lit("empty_then_start", start_cnt, 3);

    // Timeout
    idle(TO + 5);
    #1;
    lit("timeout_cnt", to_cnt, 1);
    lit("timeout_latency", to_seen - start_seen, TO);
    lit("timeout_digit_kept", int'(digit_out), 3);
    lit("timeout_no_dv", dv_cnt, 2);

    // Done on the timeout cycle
    repeat (3) frame(510, 700, 200, 400);
    #1 lit("collide_start", start_cnt, 4);
    target = start_seen + TO - 1;
    while (cyc < target) @(negedge clk);
    rec_done = 1'b1; rec_digit = 4'd9;
    @(negedge clk);
    rec_done = 1'b0;
    idle(3);
    #1;
    lit("collide_dv_cycle", dv_seen, target + 1);
    lit("collide_no_timeout", to_cnt, 1);
    lit("collide_digit", int'(digit_out), 9);

    // Busy behaviour and reset mid-BUSY
    repeat (3) frame(500, 700, 200, 400);
    frame(600, 800, 300, 500);
    frame(600, 800, 300, 500);
    #1;
    lit("busy_start_cnt", start_cnt, 5);
    lit("busy_roi_left", int'(roi_left), 500);
    lit("busy_roi_bottom", int'(roi_bottom), 400);
    lit("busy_still", int'(busy), 1);
    do_reset();
    #1;
    lit("rst_busy", int'(busy), 0);
    lit("rst_roi_left", int'(roi_left), 0);
    lit("rst_digit", int'(digit_out), 0);
    done(5);
    idle(2);
    #1 lit("rst_no_dv", dv_cnt, 3);

    // Randomized frames
    bx = 300; by = 200; bw = 120; bh = 90;
    for (int f = 0; f < 60; f++) begin
      if ($urandom_range(0, 9) == 0) begin
        bx = int'($urandom_range(100, 900)); by = int'($urandom_range(50, 500));
        bw = int'($urandom_range(10, 300));  bh = int'($urandom_range(10, 400));
      end
      l = bx + int'($urandom_range(0, 12)) - 6;
      r = bx + bw + int'($urandom_range(0, 12)) - 6;
      t = by + int'($urandom_range(0, 12)) - 6;
      b = by + bh + int'($urandom_range(0, 12)) - 6;
      if ($urandom_range(0, 7) == 0) begin
        bl = 11'(r); br = 11'(l); bt = 10'(b); bb = 10'(t);
      end else begin
        bl = 11'(l); br = 11'(r); bt = 10'(t); bb = 10'(b);
      end
      dw = int'($urandom_range(1, 3));
      gp = ($urandom_range(0, 7) == 0) ? 70 : int'($urandom_range(2, 10));
      repeat (dw) rand_cycle(1'b1);
      repeat (gp) rand_cycle(1'b0);
    end
    @(negedge clk);
    rst = 1'b0; rec_done = 1'b0;
    idle(TO + 5);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
